// File: rtl/hex_share_if.sv
// Requester-side bus of the HEX display arbiter: requests and display values
// in, grant/owner/busy status out.
interface hex_share_if #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req;
  logic [NREQ*24-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic [IW-1:0]      owner;
  logic               busy;

  modport master (output req, data, input gnt, owner, busy);
  modport slave  (input req, data, output gnt, owner, busy);
endinterface

// File: rtl/hex_share_arbiter.sv
// Round-robin owner of the six HEX displays with a minimum hold time so a
// value stays readable. All outputs come straight from registers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, displays blank, waiting for any request
// OWN   | one requester owns the displays; hold counter runs to HOLD-1
module hex_share_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 50_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  hex_share_if.slave  bus,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           r_state, w_state_nx;
  logic [NREQ-1:0]  r_gnt, w_gnt_nx;
  logic [IW-1:0]    r_owner, w_owner_nx;
  logic [IW-1:0]    r_ptr, w_ptr_nx;
  logic             r_busy, w_busy_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [5:0][6:0]  r_hex, w_hex_nx;

  logic [IW-1:0]    w_pick;
  logic             w_pick_vld;
  logic [NREQ-1:0]  w_pick_oh;
  logic             w_hold_ok;
  logic             w_own_req;
  logic             w_others;
  logic [23:0]      w_own_data;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Round-robin pick: the requester closest after r_ptr (modulo NREQ) wins;
  // the current pointer holder ends up last in the scan, not masked.
  always_comb begin
    int v_dist;
    int v_best;
    v_dist     = 0;
    v_best     = NREQ;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req[i]) begin
        v_dist = (i + NREQ - 1 - int'(r_ptr)) % NREQ;
        if (v_dist < v_best) begin
          v_best     = v_dist;
          w_pick     = IW'(i);
          w_pick_vld = 1'b1;
        end
      end
    end
  end

  // Owner-related views; r_gnt doubles as the one-hot form of r_owner.
  always_comb begin
    w_pick_oh  = '0;
    w_own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pick_oh[i] = (w_pick == IW'(i));
      if (r_gnt[i]) w_own_data = w_own_data | bus.data[i*24 +: 24];
    end
    w_own_req = |(bus.req & r_gnt);
    w_others  = |(bus.req & ~r_gnt);
    w_hold_ok = (r_cnt == HOLD_M1);
  end

  // Next-state and next-output logic for the IDLE/OWN controller.
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_busy_nx  = r_busy;
    w_cnt_nx   = r_cnt;
    w_hex_nx   = r_hex;
    case (r_state)
      IDLE: begin
        w_hex_nx = {6{BLANK}};
        if (w_pick_vld) begin
          w_state_nx = OWN;
          w_gnt_nx   = w_pick_oh;
          w_owner_nx = w_pick;
          w_ptr_nx   = w_pick;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = '0;
        end
      end
      OWN: begin
        // A dropped request freezes the display on its last captured value.
        if (w_own_req) begin
          for (int k = 0; k < 6; k++) w_hex_nx[k] = seg7(w_own_data[4*k +: 4]);
        end
        if (!w_hold_ok) begin
          w_cnt_nx = r_cnt + CW'(1);
        end else if (w_others) begin
          // Handover in the same edge: one-hot to one-hot, no idle gap.
          w_gnt_nx   = w_pick_oh;
          w_owner_nx = w_pick;
          w_ptr_nx   = w_pick;
          w_cnt_nx   = '0;
        end else if (!w_own_req) begin
          w_state_nx = IDLE;
          w_gnt_nx   = '0;
          w_owner_nx = '0;
          w_busy_nx  = 1'b0;
          w_hex_nx   = {6{BLANK}};
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins from any state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= IW'(NREQ - 1);
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_hex   <= {6{BLANK}};
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_busy  <= w_busy_nx;
      r_cnt   <= w_cnt_nx;
      r_hex   <= w_hex_nx;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.owner = r_owner;
  assign bus.busy  = r_busy;
  assign HEX0      = r_hex[0];
  assign HEX1      = r_hex[1];
  assign HEX2      = r_hex[2];
  assign HEX3      = r_hex[3];
  assign HEX4      = r_hex[4];
  assign HEX5      = r_hex[5];
endmodule

// File: tb/tb_hex_share_arbiter.sv
// Bench for hex_share_arbiter: a vector table for reset and fairness, short
// hand sequences for the multi-cycle corners, then random traffic checked
// against an ownership-level reference model.
module tb_hex_share_arbiter;
  localparam int NREQ = 4;
  localparam int HOLD = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  hex_share_if #(.NREQ(NREQ)) bus ();

  hex_share_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the displays, for how many visible cycles,
  // where the rotation pointer sits, and what each digit shows.
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [6:0] m_hex[6];
  logic [6:0] SEG[16];

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] rq);
    for (int k = 1; k <= NREQ; k++) begin
      if (rq[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [NREQ-1:0] rq,
                            input logic [NREQ*24-1:0] dt);
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = NREQ - 1;
      for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
    end else if (m_owner < 0) begin
      if (rq != 0) begin
        m_owner = rr_pick(m_ptr, rq);
        m_ptr   = m_owner;
        m_held  = 1;
      end
    end else begin
      bit own_rq;
      own_rq = rq[m_owner];
      if (own_rq) begin
        for (int k = 0; k < 6; k++) m_hex[k] = SEG[dt[m_owner*24 + 4*k +: 4]];
      end
      if (m_held < HOLD) begin
        m_held++;
      end else if ((rq & ~(NREQ'(1) << m_owner)) != 0) begin
        m_owner = rr_pick(m_ptr, rq);
        m_ptr   = m_owner;
        m_held  = 1;
      end else if (!own_rq) begin
        m_owner = -1;
        m_held  = 0;
        for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0]  e_gnt;
    logic [1:0]  e_own;
    logic [41:0] e_hex;
    e_gnt = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e_own = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e_hex = {m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    chk({tag, ".gnt"},   64'(bus.gnt),   64'(e_gnt));
    chk({tag, ".owner"}, 64'(bus.owner), 64'(e_own));
    chk({tag, ".busy"},  64'(bus.busy),  64'(m_owner >= 0));
    chk({tag, ".hex"},   64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(e_hex));
  endtask

  // Apply one cycle of inputs, advance the model, and check after the edge.
  task automatic tick(input logic rst, input logic [NREQ-1:0] rq,
                      input logic [NREQ*24-1:0] dt, input string tag);
    reset    = rst;
    bus.req  = rq;
    bus.data = dt;
    model_step(rst, rq, dt);
    @(posedge CLOCK_50);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl[23];

  initial begin
    logic [NREQ*24-1:0] dt;
    logic [NREQ-1:0]    rq;
    logic               rst;

    SEG = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_owner = -1; m_held = 0; m_ptr = NREQ - 1;
    for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
    reset = 1'b1; bus.req = '0; bus.data = '0;

    // Reset with all requesting, then steady full request: each requester
    // gets exactly HOLD cycles in order 0,1,2,3,0; then all drop.
    tbl[0] = '{1'b1, 4'hF, 4'b0000, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'hF, 4'b0000, 2'd0, 1'b0};
    for (int g = 0; g < 5; g++)
      for (int c = 0; c < 4; c++)
        tbl[2 + g*4 + c] = '{1'b0, 4'hF, 4'(1 << (g % 4)), 2'(g % 4), 1'b1};
    for (int i = 19; i < 22; i++) tbl[i].req = 4'h0;
    tbl[22] = '{1'b0, 4'h0, 4'b0000, 2'd0, 1'b0};

    dt = {24'hABCDEF, 24'h456789, 24'h0F1E2D, 24'h123456};
    for (int i = 0; i < 23; i++) begin
      tick(tbl[i].rst, tbl[i].req, dt, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.gnt", i),   64'(bus.gnt),   64'(tbl[i].gnt));
      chk($sformatf("tbl%0d.owner", i), 64'(bus.owner), 64'(tbl[i].owner));
      chk($sformatf("tbl%0d.busy", i),  64'(bus.busy),  64'(tbl[i].busy));
    end
    chk("reset.hex0_after_idle", 64'(HEX0), 64'h7F);

    // Single requester: value 012345 on requester 2.
    dt = '0;
    dt[71:48] = 24'h012345;
    tick(1'b0, 4'b0100, dt, "single.grant");
    chk("single.gnt", 64'(bus.gnt), 64'b0100);
    chk("single.hex_prev", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), {22'd0, {6{7'h7F}}});
    tick(1'b0, 4'b0100, dt, "single.c2");
    chk("single.hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}),
        64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
    tick(1'b0, 4'b0100, dt, "single.c3");
    tick(1'b0, 4'b0100, dt, "single.c4");
    tick(1'b0, 4'b0000, dt, "single.drop");
    chk("single.idle_gnt", 64'(bus.gnt), 64'd0);
    chk("single.idle_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), {22'd0, {6{7'h7F}}});

    // Early drop: requester 1 asks briefly, still owns for HOLD cycles.
    dt = '0;
    dt[47:24] = 24'h9A8B7C;
    tick(1'b0, 4'b0010, dt, "early.grant");
    tick(1'b0, 4'b0010, dt, "early.cap");
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 4'b0000, dt, "early.hold");
      chk("early.gnt_held", 64'(bus.gnt), 64'b0010);
      chk("early.frozen", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}),
          64'({7'h10, 7'h08, 7'h00, 7'h03, 7'h78, 7'h46}));
    end
    tick(1'b0, 4'b0000, dt, "early.idle");
    chk("early.idle_gnt", 64'(bus.gnt), 64'd0);

    // Sole owner keeps the displays; live data change shows one cycle later.
    dt = '0;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 4'b0001, dt, "sole");
      chk("sole.gnt", 64'(bus.gnt), 64'b0001);
    end
    dt[23:0] = 24'hFFFFFF;
    tick(1'b0, 4'b0001, dt, "sole.ff");
    chk("sole.hex_F", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{7'h0E}}));

    // Reset in the second cycle of a fresh grant, then requester 3 alone.
    tick(1'b0, 4'b0000, dt, "mid.idle");
    tick(1'b0, 4'b0010, dt, "mid.grant");
    tick(1'b0, 4'b0010, dt, "mid.c2");
    tick(1'b1, 4'b0010, dt, "mid.reset");
    chk("mid.reset_gnt",  64'(bus.gnt),  64'd0);
    chk("mid.reset_busy", 64'(bus.busy), 64'd0);
    chk("mid.reset_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), {22'd0, {6{7'h7F}}});
    tick(1'b0, 4'b1000, dt, "mid.after");
    chk("mid.after_gnt", 64'(bus.gnt), 64'b1000);

    // Random traffic with sticky requests, data churn and rare resets.
    rq = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) dt = {$urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 199) == 0);
      tick(rst, rq, dt, $sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
